// File: rtl/sme_alu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sme_alu_ctrl                                               |
// | Description : Sequencing controller for the SME masked ALU. Accepts one  |
// |               masked instruction from issue, latches opcode, shift       |
// |               amount and operand shares, optionally waits for an RNG     |
// |               refresh (non-linear ops), drives the ALU op strobes until  |
// |               the ALU is ready, and holds the result shares on a         |
// |               valid/ready response port. Also owns ALU flush and a hang  |
// |               watchdog.                                                  |
// | Option      : SME_ALU_CTRL_RNG_REFRESH_EN - when defined, non-linear ops |
// |               pass through an RNG refresh wait before execution.         |
// | Ports       : g_clk, g_reset (async, active-high)                        |
// |               flush                       - abort current operation      |
// |               req_valid/req_ready/req_op/req_shamt/req_rs1/req_rs2       |
// |                                           - dispatch request             |
// |               rng_req/rng_valid           - RNG refresh handshake        |
// |               alu_valid/alu_ready/alu_flush/alu_shamt/alu_op_*/          |
// |               alu_rs1/alu_rs2/alu_rd      - ALU control and data         |
// |               rsp_valid/rsp_ready/rsp_err/rsp_rd - response port         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sme_alu_ctrl #(
    parameter int XLEN = 32,
    parameter int SMAX = 4,
    parameter int WDOG = 15
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [4:0]             req_shamt,
    input  logic [XLEN*SMAX-1:0]   req_rs1,
    input  logic [XLEN*SMAX-1:0]   req_rs2,
    output logic                   rng_req,
    input  logic                   rng_valid,
    output logic                   alu_valid,
    input  logic                   alu_ready,
    output logic                   alu_flush,
    output logic [4:0]             alu_shamt,
    output logic                   alu_op_xor,
    output logic                   alu_op_and,
    output logic                   alu_op_or,
    output logic                   alu_op_notrs2,
    output logic                   alu_op_shift,
    output logic                   alu_op_rotate,
    output logic                   alu_op_left,
    output logic                   alu_op_right,
    output logic                   alu_op_add,
    output logic                   alu_op_sub,
    output logic                   alu_op_mask,
    output logic                   alu_op_unmask,
    output logic                   alu_op_remask,
    output logic [XLEN*SMAX-1:0]   alu_rs1,
    output logic [XLEN*SMAX-1:0]   alu_rs2,
    input  logic [XLEN*SMAX-1:0]   alu_rd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_err,
    output logic [XLEN*SMAX-1:0]   rsp_rd
);

    localparam int c_w = XLEN * SMAX;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rng  = 2'd1;
    localparam logic [1:0] c_st_exec = 2'd2;
    localparam logic [1:0] c_st_hold = 2'd3;

    localparam logic [3:0] c_op_xor    = 4'd0;
    localparam logic [3:0] c_op_xnor   = 4'd1;
    localparam logic [3:0] c_op_and    = 4'd2;
    localparam logic [3:0] c_op_andn   = 4'd3;
    localparam logic [3:0] c_op_or     = 4'd4;
    localparam logic [3:0] c_op_orn    = 4'd5;
    localparam logic [3:0] c_op_sll    = 4'd6;
    localparam logic [3:0] c_op_srl    = 4'd7;
    localparam logic [3:0] c_op_ror    = 4'd8;
    localparam logic [3:0] c_op_rol    = 4'd9;
    localparam logic [3:0] c_op_add    = 4'd10;
    localparam logic [3:0] c_op_sub    = 4'd11;
    localparam logic [3:0] c_op_mask   = 4'd12;
    localparam logic [3:0] c_op_unmask = 4'd13;
    localparam logic [3:0] c_op_remask = 4'd14;
    localparam logic [3:0] c_op_ill    = 4'd15;

    // Last count value that still allows another EXEC cycle; reaching WDOG
    // on the following increment aborts the operation.
    localparam logic [3:0] c_wdog_last = 4'(WDOG - 1);

`ifdef SME_ALU_CTRL_RNG_REFRESH_EN
    localparam bit c_rng_en = 1'b1;
`else
    localparam bit c_rng_en = 1'b0;
`endif

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [3:0]     r_op;
    logic [4:0]     r_shamt;
    logic [c_w-1:0] r_rs1;
    logic [c_w-1:0] r_rs2;
    logic [3:0]     r_wdog_cnt;
    logic [c_w-1:0] r_rsp_rd;
    logic           r_rsp_err;
    logic           r_alu_flush;

    logic           w_accept;
    logic           w_exec_done;
    logic           w_wdog_expire;
    logic           w_req_nonlinear;

    // Operations whose masked implementation consumes fresh randomness.
    assign w_req_nonlinear = (req_op == c_op_and)  || (req_op == c_op_andn) ||
                             (req_op == c_op_or)   || (req_op == c_op_orn)  ||
                             (req_op == c_op_add)  || (req_op == c_op_sub)  ||
                             (req_op == c_op_mask) || (req_op == c_op_remask);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_exec_done   = 1'b0;
        w_wdog_expire = 1'b0;
        req_ready     = 1'b0;
        rng_req       = 1'b0;
        alu_valid     = 1'b0;
        rsp_valid     = 1'b0;
        alu_op_xor    = 1'b0;
        alu_op_and    = 1'b0;
        alu_op_or     = 1'b0;
        alu_op_notrs2 = 1'b0;
        alu_op_shift  = 1'b0;
        alu_op_rotate = 1'b0;
        alu_op_left   = 1'b0;
        alu_op_right  = 1'b0;
        alu_op_add    = 1'b0;
        alu_op_sub    = 1'b0;
        alu_op_mask   = 1'b0;
        alu_op_unmask = 1'b0;
        alu_op_remask = 1'b0;

        case (r_state)
            c_st_idle: begin
                req_ready = ~flush;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_op == c_op_ill) begin
                        w_state_nxt = c_st_hold;
                    end else if (c_rng_en && w_req_nonlinear) begin
                        w_state_nxt = c_st_rng;
                    end else begin
                        w_state_nxt = c_st_exec;
                    end
                end
            end
            c_st_rng: begin
                rng_req = c_rng_en;
                if (rng_valid) begin
                    w_state_nxt = c_st_exec;
                end
            end
            c_st_exec: begin
                alu_valid = 1'b1;
                case (r_op)
                    c_op_xor:    alu_op_xor = 1'b1;
                    c_op_xnor:   begin alu_op_xor = 1'b1; alu_op_notrs2 = 1'b1; end
                    c_op_and:    alu_op_and = 1'b1;
                    c_op_andn:   begin alu_op_and = 1'b1; alu_op_notrs2 = 1'b1; end
                    c_op_or:     alu_op_or = 1'b1;
                    c_op_orn:    begin alu_op_or = 1'b1; alu_op_notrs2 = 1'b1; end
                    c_op_sll:    begin alu_op_shift = 1'b1; alu_op_left = 1'b1; end
                    c_op_srl:    begin alu_op_shift = 1'b1; alu_op_right = 1'b1; end
                    c_op_ror:    begin alu_op_rotate = 1'b1; alu_op_right = 1'b1; end
                    c_op_rol:    begin alu_op_rotate = 1'b1; alu_op_left = 1'b1; end
                    c_op_add:    alu_op_add = 1'b1;
                    c_op_sub:    alu_op_sub = 1'b1;
                    c_op_mask:   alu_op_mask = 1'b1;
                    c_op_unmask: alu_op_unmask = 1'b1;
                    c_op_remask: alu_op_remask = 1'b1;
                    default:     ;
                endcase
                // A ready ALU wins over a watchdog that would expire in the
                // same cycle: the result is valid, so keep it.
                if (alu_ready) begin
                    w_exec_done = 1'b1;
                    w_state_nxt = c_st_hold;
                end else if (r_wdog_cnt == c_wdog_last) begin
                    w_wdog_expire = 1'b1;
                    w_state_nxt   = c_st_hold;
                end
            end
            c_st_hold: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase

        // Flush overrides every handshake seen in the same cycle.
        if (flush) begin
            w_state_nxt   = c_st_idle;
            w_accept      = 1'b0;
            w_exec_done   = 1'b0;
            w_wdog_expire = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request latches, response capture, watchdog and flush pulse
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_op        <= 4'd0;
            r_shamt     <= 5'd0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_wdog_cnt  <= 4'd0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= 1'b0;
            r_alu_flush <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= req_op;
                r_shamt <= req_shamt;
                r_rs1   <= req_rs1;
                r_rs2   <= req_rs2;
            end

            // Response fields only move on entry to HOLD so that a held
            // response stays stable until it is consumed.
            if (w_accept && (req_op == c_op_ill)) begin
                r_rsp_rd  <= '0;
                r_rsp_err <= 1'b1;
            end else if (w_exec_done) begin
                r_rsp_rd  <= alu_rd;
                r_rsp_err <= 1'b0;
            end else if (w_wdog_expire) begin
                r_rsp_rd  <= '0;
                r_rsp_err <= 1'b1;
            end

            if ((w_state_nxt == c_st_exec) && (r_state != c_st_exec)) begin
                r_wdog_cnt <= 4'd0;
            end else if ((r_state == c_st_exec) && !alu_ready) begin
                r_wdog_cnt <= r_wdog_cnt + 4'd1;
            end

            r_alu_flush <= flush | w_wdog_expire;
        end
    end

    assign alu_flush = r_alu_flush;
    assign alu_shamt = r_shamt;
    assign alu_rs1   = r_rs1;
    assign alu_rs2   = r_rs2;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: doc/sme_alu_ctrl.md
# sme_alu_ctrl

Sequencing controller for the SME masked ALU. It accepts one masked instruction at a time from the issue stage and latches the opcode, shift amount and operand shares. For non-linear operations it optionally obtains fresh randomness, then drives the ALU op strobes and `valid` until the ALU reports `ready`. It captures the result shares and holds them on a valid/ready response port until writeback consumes them. It sits between the SME issue logic and `sme_alu`, and also owns ALU flush and a hang watchdog.

## Interface
- `XLEN`, 32, data width per share.
- `SMAX`, 4, number of hardware shares.
- `WDOG`, 15, maximum EXEC cycles before abort (4-bit counter).

- `g_clk` in 1: global clock.
- `g_reset` in 1: asynchronous, active-high reset.
- `flush` in 1: discard current operation.
- `req_valid` in 1: dispatch request.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 4: opcode.
- `req_shamt` in 5: shift amount.
- `req_rs1`, `req_rs2` in XLEN×SMAX: operand shares.
- `rng_req` out 1: request a fresh RNG refresh.
- `rng_valid` in 1: refresh complete.
- `alu_valid` out 1: ALU valid.
- `alu_ready` in 1: ALU ready.
- `alu_flush` out 1: ALU flush.
- `alu_shamt` out 5: ALU shift amount.
- `alu_op_*` out 1 each: xor, and, or, notrs2, shift, rotate, left, right, add, sub, mask, unmask, remask.
- `alu_rs1`, `alu_rs2` out XLEN×SMAX: latched operand shares.
- `alu_rd` in XLEN×SMAX: ALU result shares.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_err` out 1: illegal opcode or watchdog abort.
- `rsp_rd` out XLEN×SMAX: result shares.

## Operation
- Opcodes:
  - 0 XOR, 1 XNOR (xor+notrs2)
  - 2 AND, 3 ANDN (and+notrs2), 4 OR, 5 ORN (or+notrs2)
  - 6 SLL (shift+left), 7 SRL (shift+right), 8 ROR (rotate+right), 9 ROL (rotate+left)
  - 10 ADD, 11 SUB
  - 12 MASK, 13 UNMASK, 14 REMASK
  - 15 illegal
- Non-linear set (needs RNG): 2, 3, 4, 5, 10, 11, 12, 14.
- States: IDLE, RNG, EXEC, HOLD.
  - IDLE: `req_ready`=1 unless `flush`. On an accepted request, latch op, shamt and shares. Opcode 15 goes to HOLD with `rsp_err`=1 and `rsp_rd`=0. A non-linear op goes to RNG (see Configuration). Otherwise go to EXEC.
  - RNG: `rng_req`=1. On `rng_valid`, go to EXEC.
  - EXEC: `alu_valid`=1 and the decoded strobes are asserted. `alu_rs1`, `alu_rs2` and `alu_shamt` are driven from the latches. On `alu_ready`, capture `alu_rd` into `rsp_rd`, set `rsp_err`=0 and go to HOLD.
  - HOLD: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Decoded strobes are zero outside EXEC.
- Watchdog:
  - A 4-bit counter clears on EXEC entry and increments each EXEC cycle without `alu_ready`.
  - On the cycle the count reaches `WDOG`: pulse `alu_flush`, go to HOLD with `rsp_err`=1 and `rsp_rd`=0.
- Flush: from any state, the next state is IDLE and `alu_flush`=1 for that cycle.
  - Latched request and pending response are discarded. No `rsp_valid` is produced.
  - Flush overrides `alu_ready`, `rng_valid` and `rsp_ready` in the same cycle.
- `rsp_rd` and `rsp_err` change only on HOLD entry.

## Timing
- Reset: state IDLE, all latches 0, counter 0.
- Reset values of outputs: `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rd`=0, `alu_valid`=0, `alu_flush`=0, `rng_req`=0, all strobes 0.
- Reset asserted mid-operation aborts immediately with no response.
- Linear op with single-cycle ALU: accept at cycle 0, EXEC at 1, `rsp_valid` at 2.
- Non-linear op: the RNG wait is inserted before EXEC. EXEC lasts until `alu_ready` (multi-cycle for add/sub).
- `req_ready` is low in RNG, EXEC and HOLD. After a HOLD handshake, the next accept is one cycle later at the earliest.
- `rsp_valid`, once high, stays high and `rsp_rd` stays stable until `rsp_ready` or `flush`.
- `alu_flush` is a registered single-cycle pulse.

## Configuration
- `SME_ALU_CTRL_RNG_REFRESH_EN`:
  - Defined: non-linear ops pass through RNG and wait for `rng_valid`.
  - Undefined: the RNG state is never entered, `rng_req` is tied 0, and non-linear ops go straight from IDLE to EXEC.

## Test plan
- XOR (op 0), rs1 shares {1,2,3,4}, rs2 {0,0,0,1}, single-cycle `alu_ready` -> `rsp_valid` at cycle 2, `rsp_rd` equals `alu_rd` sampled in EXEC, `rsp_err`=0, `alu_op_xor`=1 only in EXEC.
- ADD (op 10) with RNG_EN, `rng_valid` after 3 cycles, `alu_ready` after 5 EXEC cycles -> `rng_req` high 3 cycles, `alu_valid` high 5 cycles, then `rsp_valid`; `req_ready`=0 throughout.
- Opcode 15 -> HOLD next cycle, `rsp_err`=1, `rsp_rd`=0, ALU never sees `alu_valid`.
- SUB with `alu_ready` held 0 -> after 15 EXEC cycles `alu_flush` pulses once, `rsp_err`=1.
- `flush` during EXEC coincident with `alu_ready` -> IDLE next cycle, `alu_flush`=1, no `rsp_valid`; `flush` with `req_valid` in IDLE -> request not accepted.
- HOLD with `rsp_ready`=0 for 10 cycles -> `rsp_valid` and `rsp_rd` stable; `rsp_ready`=1 -> IDLE, `req_ready`=1 next cycle.
